// File: rtl/hwce_sop_norm.sv
// Normalization stage behind the HWCE sum-of-products: optional y_in accumulate,
// rounding arithmetic right shift by qf, saturation to CONV_WIDTH, two-stage valid/ready pipe.
module hwce_sop_norm #(
   parameter int NPX           = 4,
   parameter int CONV_WIDTH    = 16,
   parameter int SUM_WIDTH     = 48,
   parameter int QF_WIDTH      = 5,
   parameter int SAT_CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        acc_en,
   input  logic [QF_WIDTH-1:0]         qf,
   input  logic [NPX*SUM_WIDTH-1:0]    sop_in,
   input  logic                        sop_valid,
   output logic                        sop_ready,
   input  logic [NPX*CONV_WIDTH-1:0]   y_in,
   input  logic                        y_in_valid,
   output logic                        y_in_ready,
   output logic [NPX*CONV_WIDTH-1:0]   y_out,
   output logic                        y_out_valid,
   input  logic                        y_out_ready,
   output logic [SAT_CNT_WIDTH-1:0]    sat_cnt
);

   localparam int AW = SUM_WIDTH + 2;
   localparam int NW = $clog2(NPX + 1);
   localparam logic signed [AW-1:0] C_MAX = AW'((64'sd1 <<< (CONV_WIDTH - 1)) - 64'sd1);
   localparam logic signed [AW-1:0] C_MIN = ~C_MAX;

   logic                            w_flush;
   logic                            w_s2_adv;
   logic                            w_s1_adv;
   logic                            w_in_fire;
   logic                            w_s2_load;
   logic signed [AW-1:0]            w_round;
   logic signed [AW-1:0]            w_s1_next [NPX];
   logic signed [AW-1:0]            w_t       [NPX];
   logic        [NPX-1:0]           w_sat;
   logic        [NPX*CONV_WIDTH-1:0] w_y_next;
   logic        [NW-1:0]            w_nsat;
   logic        [SAT_CNT_WIDTH:0]   w_cnt_sum;

   logic                            r_s1_valid;
   logic                            r_s2_valid;
   logic signed [AW-1:0]            r_s1_sum  [NPX];
   logic        [NPX*CONV_WIDTH-1:0] r_y_out;
   logic        [SAT_CNT_WIDTH-1:0] r_sat_cnt;

   // A stage loads when it is empty or the stage after it frees up in the same cycle; a beat
   // transfers when valid & ready are both high, and rst/clear force both input readies low.
   assign w_flush    = rst | clear;
   assign w_s2_adv   = ~r_s2_valid | y_out_ready;
   assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
   assign sop_ready  = ~w_flush & w_s1_adv & (~acc_en | y_in_valid);
   assign y_in_ready = ~w_flush & w_s1_adv & sop_valid & acc_en;
   assign w_in_fire  = sop_valid & sop_ready;
   assign w_s2_load  = ~w_flush & r_s1_valid & w_s2_adv;
   assign w_round    = (qf != '0) ? (AW'(1) << (qf - QF_WIDTH'(1))) : '0;

   always_comb begin
      for (int n = 0; n < NPX; n++) begin
         w_s1_next[n] = AW'(signed'(sop_in[n*SUM_WIDTH +: SUM_WIDTH])) + w_round;
         if (acc_en)
            w_s1_next[n] = w_s1_next[n] + (AW'(signed'(y_in[n*CONV_WIDTH +: CONV_WIDTH])) <<< qf);
      end
   end

   always_comb begin
      w_nsat   = '0;
      w_y_next = '0;
      for (int n = 0; n < NPX; n++) begin
         w_t[n]   = r_s1_sum[n] >>> qf;
         w_sat[n] = (w_t[n] > C_MAX) || (w_t[n] < C_MIN);
         if (w_t[n] > C_MAX)
            w_y_next[n*CONV_WIDTH +: CONV_WIDTH] = {1'b0, {(CONV_WIDTH-1){1'b1}}};
         else if (w_t[n] < C_MIN)
            w_y_next[n*CONV_WIDTH +: CONV_WIDTH] = {1'b1, {(CONV_WIDTH-1){1'b0}}};
         else
            w_y_next[n*CONV_WIDTH +: CONV_WIDTH] = w_t[n][CONV_WIDTH-1:0];
         w_nsat = w_nsat + NW'(w_sat[n]);
      end
      w_cnt_sum = {1'b0, r_sat_cnt} + (SAT_CNT_WIDTH+1)'(w_nsat);
   end

   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_y_out    <= '0;
         r_sat_cnt  <= '0;
      end else begin
         r_s1_valid <= w_in_fire | (r_s1_valid & ~w_s2_adv);
         r_s2_valid <= w_s2_load | (r_s2_valid & ~y_out_ready);
         if (w_s2_load) begin
            r_y_out   <= w_y_next;
            // The counter sticks at all-ones instead of wrapping.
            r_sat_cnt <= w_cnt_sum[SAT_CNT_WIDTH] ? '1 : w_cnt_sum[SAT_CNT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         for (int n = 0; n < NPX; n++)
            r_s1_sum[n] <= w_s1_next[n];
      end
   end

   assign y_out       = r_y_out;
   assign y_out_valid = r_s2_valid;
   assign sat_cnt     = r_sat_cnt;

endmodule

// File: tb/tb_hwce_sop_norm.sv
// Bench for hwce_sop_norm: directed cases plus randomized streams checked every cycle
// against an arithmetic model of round/shift/saturate and a FIFO view of the pipeline.
module tb_hwce_sop_norm;

   localparam int NPX = 4;
   localparam int CW  = 16;
   localparam int SW  = 48;
   localparam int QW  = 5;
   localparam int SCW = 16;
   localparam int VW  = NPX * CW;

   logic              clk;
   logic              rst;
   logic              clear;
   logic              acc_en;
   logic [QW-1:0]     qf;
   logic [NPX*SW-1:0] sop_in;
   logic              sop_valid;
   logic              sop_ready;
   logic [VW-1:0]     y_in;
   logic              y_in_valid;
   logic              y_in_ready;
   logic [VW-1:0]     y_out;
   logic              y_out_valid;
   logic              y_out_ready;
   logic [SCW-1:0]    sat_cnt;

   hwce_sop_norm #(
      .NPX(NPX), .CONV_WIDTH(CW), .SUM_WIDTH(SW), .QF_WIDTH(QW), .SAT_CNT_WIDTH(SCW)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear), .acc_en(acc_en), .qf(qf),
      .sop_in(sop_in), .sop_valid(sop_valid), .sop_ready(sop_ready),
      .y_in(y_in), .y_in_valid(y_in_valid), .y_in_ready(y_in_ready),
      .y_out(y_out), .y_out_valid(y_out_valid), .y_out_ready(y_out_ready),
      .sat_cnt(sat_cnt)
   );

   int            n_tests;
   int            n_fail;
   int            cyc;
   int            n_pop;
   int            cum_sat;
   logic [VW-1:0] exp_q[$];
   int            cyc_q[$];
   int            sat_q[$];
   bit            after_flush;
   bit            hold_valid;
   logic [VW-1:0] hold_val;

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [CW-1:0] model_pix(input longint s, input longint y, input bit acc,
                                               input int q, output bit sat);
      longint v, num, d, t;
      v   = s + (acc ? y * (64'sd1 <<< q) : 64'sd0);
      // round half up: floor(v / 2^q + 1/2) == floor((2v + 2^q) / 2^(q+1))
      num = 2 * v + (64'sd1 <<< q);
      d   = 64'sd1 <<< (q + 1);
      t   = (num >= 0) ? num / d : -((-num + d - 1) / d);
      sat = 1'b0;
      if (t > 32767) begin
         sat = 1'b1;
         return 16'h7FFF;
      end
      if (t < -32768) begin
         sat = 1'b1;
         return 16'h8000;
      end
      return t[CW-1:0];
   endfunction

   function automatic logic [VW-1:0] model_vec(input logic [NPX*SW-1:0] s, input logic [VW-1:0] y,
                                               input bit acc, input int q, output int nsat);
      logic [VW-1:0]        r;
      logic signed [SW-1:0] sp;
      logic signed [CW-1:0] yp;
      bit                   st;
      nsat = 0;
      for (int n = 0; n < NPX; n++) begin
         sp = s[n*SW +: SW];
         yp = y[n*CW +: CW];
         r[n*CW +: CW] = model_pix(longint'(sp), longint'(yp), acc, q, st);
         nsat += int'(st);
      end
      return r;
   endfunction

   function automatic logic [NPX*SW-1:0] pack4(input longint a, input longint b,
                                                input longint c, input longint d);
      return {d[SW-1:0], c[SW-1:0], b[SW-1:0], a[SW-1:0]};
   endfunction

   function automatic logic [VW-1:0] pack16(input longint a, input longint b,
                                            input longint c, input longint d);
      return {d[CW-1:0], c[CW-1:0], b[CW-1:0], a[CW-1:0]};
   endfunction

   function automatic logic [SW-1:0] rand_pix(input int q);
      longint v;
      if ($urandom_range(0, 3) == 0) begin
         v = {$urandom, $urandom};
      end else begin
         v = longint'(int'($urandom));
         v = v >>> ((q < 16) ? 16 - q : 0);
      end
      return v[SW-1:0];
   endfunction

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin : cmp
      bit            exp_valid;
      bit            adv;
      int            ns;
      logic [VW-1:0] e;
      cyc++;
      if (rst || clear) begin
         check("flush_sop_ready", sop_ready, 0);
         check("flush_y_in_ready", y_in_ready, 0);
         exp_q.delete();
         cyc_q.delete();
         sat_q.delete();
         cum_sat     = 0;
         after_flush = 1'b1;
         hold_valid  = 1'b0;
      end else begin
         exp_valid = (exp_q.size() > 0) && (cyc_q[0] <= cyc - 2);
         check("y_out_valid", y_out_valid, exp_valid);
         if (after_flush) begin
            check("post_flush_y_out", y_out, 0);
            check("post_flush_sat_cnt", sat_cnt, 0);
            after_flush = 1'b0;
         end
         if (hold_valid)
            check("stall_y_out_stable", y_out, hold_val);
         adv = (exp_q.size() < 2) || y_out_ready;
         check("sop_ready", sop_ready, adv && (!acc_en || y_in_valid));
         check("y_in_ready", y_in_ready, adv && sop_valid && acc_en);
         if (y_out_valid && y_out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", y_out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               void'(cyc_q.pop_front());
               ns = sat_q.pop_front();
               check("y_out", y_out, e);
               check("sat_cnt", sat_cnt, ns);
               n_pop++;
            end
         end
         hold_valid = y_out_valid && !y_out_ready;
         hold_val   = y_out;
         if (sop_valid && sop_ready) begin
            e       = model_vec(sop_in, y_in, acc_en, int'(qf), ns);
            cum_sat = (cum_sat + ns > 65535) ? 65535 : cum_sat + ns;
            exp_q.push_back(e);
            cyc_q.push_back(cyc);
            sat_q.push_back(cum_sat);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_drain();
      @(posedge clk); #1;
      sop_valid   = 1'b0;
      y_in_valid  = 1'b0;
      y_out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check("drain", exp_q.size(), 0);
   endtask

   task automatic set_cfg(input bit acc, input int q);
      wait_drain();
      acc_en = acc;
      qf     = QW'(q);
   endtask

   task automatic wait_fire(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = sop_valid && sop_ready;
      end
      check({name, "_fire"}, ok, 1);
   endtask

   task automatic send_expect(input logic [NPX*SW-1:0] s, input logic [VW-1:0] y,
                              input logic [VW-1:0] ey, input string name);
      @(posedge clk); #1;
      sop_in      = s;
      y_in        = y;
      sop_valid   = 1'b1;
      y_in_valid  = acc_en;
      y_out_ready = 1'b1;
      wait_fire(name);
      @(posedge clk); #1;
      sop_valid  = 1'b0;
      y_in_valid = 1'b0;
      @(negedge clk);
      check({name, "_lat1_valid"}, y_out_valid, 0);
      @(negedge clk);
      check({name, "_lat2_valid"}, y_out_valid, 1);
      check({name, "_data"}, y_out, ey);
   endtask

   task automatic stream_const(input logic [NPX*SW-1:0] s, input int n);
      int cnt;
      @(posedge clk); #1;
      sop_in      = s;
      sop_valid   = 1'b1;
      y_out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 2 * n + 50 && cnt < n; i++) begin
         @(negedge clk);
         if (sop_valid && sop_ready) cnt++;
      end
      @(posedge clk); #1;
      sop_valid = 1'b0;
      check("stream_count", cnt, n);
   endtask

   task automatic pulse_flush(input bit use_rst);
      @(posedge clk); #1;
      if (use_rst) rst = 1'b1;
      else         clear = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      clear = 1'b0;
      @(negedge clk);
      check("flush_valid", y_out_valid, 0);
      check("flush_sat_cnt", sat_cnt, 0);
      check("flush_y_out", y_out, 0);
   endtask

   task automatic backpressure_test();
      int sent;
      int pops0;
      bit fired;
      bit saw_low;
      set_cfg(0, 0);
      pops0   = n_pop;
      sent    = 0;
      fired   = 1'b0;
      saw_low = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (fired) sent++;
         y_out_ready = !(c >= 3 && c <= 8);
         sop_valid   = (sent < 6);
         sop_in      = pack4(100 * sent + 1, -100 * sent, 1000 + sent, -sent);
         @(negedge clk);
         fired = sop_valid && sop_ready;
         if (!sop_ready) saw_low = 1'b1;
      end
      wait_drain();
      check("bp_sop_ready_fell", saw_low, 1);
      check("bp_output_count", n_pop - pops0, 6);
   endtask

   task automatic random_run(input int ncyc, input bit acc, input int q);
      bit fired_s;
      bit fired_y;
      set_cfg(acc, q);
      fired_s = 1'b0;
      fired_y = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         if (!sop_valid || fired_s) begin
            sop_valid = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < NPX; n++) sop_in[n*SW +: SW] = rand_pix(q);
         end
         if (!y_in_valid || fired_y) begin
            y_in_valid = ($urandom_range(0, 3) != 0);
            y_in       = {$urandom, $urandom};
         end
         y_out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         fired_s = sop_valid && sop_ready;
         fired_y = y_in_valid && y_in_ready;
      end
      wait_drain();
   endtask

   task automatic flush_test(input bit use_rst, input string name);
      set_cfg(0, 0);
      @(posedge clk); #1;
      y_out_ready = 1'b0;
      sop_valid   = 1'b1;
      sop_in      = pack4(40000, -40000, 7, 8);
      wait_fire({name, "_a"});
      @(posedge clk); #1;
      sop_in = pack4(-40000, 3, 40000, 9);
      wait_fire({name, "_b"});
      @(posedge clk); #1;
      sop_valid = 1'b0;
      @(negedge clk);
      check({name, "_full_valid"}, y_out_valid, 1);
      check({name, "_full_sop_ready"}, sop_ready, 0);
      pulse_flush(use_rst);
      send_expect(pack4(1, 2, 3, -4), '0, pack16(1, 2, 3, -4), name);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit st;
      n_tests     = 0;
      n_fail      = 0;
      cyc         = 0;
      n_pop       = 0;
      cum_sat     = 0;
      rst         = 1'b1;
      clear       = 1'b0;
      acc_en      = 1'b0;
      qf          = '0;
      sop_in      = '0;
      sop_valid   = 1'b0;
      y_in        = '0;
      y_in_valid  = 1'b0;
      y_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_valid", y_out_valid, 0);
      check("reset_sat_cnt", sat_cnt, 0);
      check("reset_y_out", y_out, 0);
      check("reset_sop_ready", sop_ready, 1);
      check("reset_y_in_ready", y_in_ready, 0);

      check("model_round_pos", model_pix(24, 0, 0, 4, st), 16'd2);
      check("model_round_neg", model_pix(-24, 0, 0, 4, st), 16'hFFFF);
      check("model_round_23", model_pix(23, 0, 0, 4, st), 16'd1);
      check("model_round_half", model_pix(8, 0, 0, 4, st), 16'd1);
      check("model_acc", model_pix(384, 3, 1, 8, st), 16'd5);
      check("model_sat_neg", model_pix(-40000, 0, 0, 0, st), 16'h8000);
      check("model_sat_flag", st, 1);

      set_cfg(0, 0);
      send_expect(pack4(5, -7, 32767, -32768), '0, pack16(5, -7, 32767, -32768), "pass");
      check("pass_sat_cnt", sat_cnt, 0);

      set_cfg(0, 4);
      send_expect(pack4(24, -24, 23, 8), '0, pack16(2, -1, 1, 1), "round");

      set_cfg(1, 8);
      @(posedge clk); #1;
      sop_in      = pack4(384, 0, 0, 0);
      y_in        = pack16(3, 0, 0, 0);
      sop_valid   = 1'b1;
      y_in_valid  = 1'b0;
      y_out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("acc_wait_sop_ready", sop_ready, 0);
         check("acc_wait_no_output", y_out_valid, 0);
      end
      @(posedge clk); #1;
      y_in_valid = 1'b1;
      @(negedge clk);
      check("acc_sop_ready", sop_ready, 1);
      check("acc_y_in_ready", y_in_ready, 1);
      @(posedge clk); #1;
      sop_valid  = 1'b0;
      y_in_valid = 1'b0;
      @(negedge clk);
      check("acc_lat1_valid", y_out_valid, 0);
      @(negedge clk);
      check("acc_lat2_valid", y_out_valid, 1);
      check("acc_data", y_out, pack16(5, 0, 0, 0));

      set_cfg(0, 0);
      pulse_flush(1'b0);
      send_expect(pack4(40000, -40000, 48'h7FFF_FFFF_FFFF, 1), '0,
                  pack16(16'h7FFF, 16'h8000, 16'h7FFF, 1), "sat");
      check("sat_cnt_3", sat_cnt, 3);

      pulse_flush(1'b0);
      stream_const(pack4(40000, -40000, 40000, -40000), 16383);
      stream_const(pack4(40000, -40000, 0, 0), 1);
      wait_drain();
      check("sat_cnt_fffe", sat_cnt, 16'hFFFE);
      stream_const(pack4(40000, -40000, 40000, 1), 1);
      wait_drain();
      check("sat_cnt_clamp", sat_cnt, 16'hFFFF);

      backpressure_test();

      random_run(600, 0, 0);
      random_run(600, 1, 4);
      random_run(600, 0, 7);
      random_run(600, 1, 12);
      random_run(600, 1, 0);
      random_run(400, 0, 20);
      random_run(400, 1, 31);

      flush_test(1'b0, "flush_clear");
      flush_test(1'b1, "flush_rst");

      wait_drain();
      check("outputs_seen", n_pop > 1000, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
